branch_predictor_btb: RTL and testbench

Fetch-stage branch predictor. It consumes the resolution/update interface driven by the decode stage and returns a next-PC prediction for the current fetch PC.
- Direction predictor: 256-entry pattern history table (PHT) of 2-bit saturating counters.
- Target predictor: 64-entry direct-mapped branch target buffer (BTB).
- Lookup is combinational in the same cycle as fetch. Updates commit on the rising clock edge.

---
 rtl/branch_predictor_btb.sv | 77 +++++++
 tb/tb_branch_predictor_btb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// Fetch-stage branch predictor: 2-bit saturating PHT for direction plus a
// direct-mapped BTB for targets. Lookup is combinational; updates commit on clk.
module branch_predictor_btb #(
   parameter int         PHT_ENTRIES = 256,
   parameter int         BTB_ENTRIES = 64,
   parameter int         TAG_WIDTH   = 20,
   parameter logic [1:0] CTR_RESET   = 2'b01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] fetch_pc,
   input  logic        pred_update_en,
   input  logic [7:0]  pred_update_index,
   input  logic        pred_update_taken,
   input  logic        btb_update_en,
   input  logic [5:0]  btb_update_index,
   input  logic [19:0] btb_update_tag,
   input  logic [31:0] btb_update_target,
   output logic        pred_taken,
   output logic        pred_btb_hit,
   output logic [31:0] pred_target,
   output logic [31:0] pred_next_pc,
   output logic [1:0]  pred_ctr
);

   logic [1:0]           pht        [PHT_ENTRIES];
   logic                 btb_valid  [BTB_ENTRIES];
   logic [TAG_WIDTH-1:0] btb_tag    [BTB_ENTRIES];
   logic [31:0]          btb_target [BTB_ENTRIES];

   logic [7:0]           pht_idx;
   logic [5:0]           btb_idx;
   logic [TAG_WIDTH-1:0] fetch_tag;
   logic                 unused_pc_bits;

   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      if (taken)
         return (ctr == 2'b11) ? ctr : ctr + 2'd1;
      else
         return (ctr == 2'b00) ? ctr : ctr - 2'd1;
   endfunction

   assign pht_idx        = fetch_pc[9:2];
   assign btb_idx        = fetch_pc[11:6];
   assign fetch_tag      = fetch_pc[31:12];
   assign unused_pc_bits = ^fetch_pc[1:0];

   // Reads see pre-update state; a same-cycle write becomes visible next cycle.
   always_comb begin
      pred_ctr     = pht[pht_idx];
      pred_btb_hit = btb_valid[btb_idx] && (btb_tag[btb_idx] == fetch_tag);
      pred_target  = pred_btb_hit ? btb_target[btb_idx] : 32'h0;
      pred_taken   = pred_btb_hit && pred_ctr[1];
      pred_next_pc = pred_taken ? pred_target : fetch_pc + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PHT_ENTRIES; i++)
            pht[i] <= CTR_RESET;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= 32'h0;
         end
      end else begin
         if (pred_update_en)
            pht[pred_update_index] <= ctr_next(pht[pred_update_index], pred_update_taken);
         if (btb_update_en) begin
            btb_valid[btb_update_index]  <= 1'b1;
            btb_tag[btb_update_index]    <= btb_update_tag;
            btb_target[btb_update_index] <= btb_update_target;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: stimulus queues expected lookups,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor_btb;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fetch_pc;
   logic        pred_update_en;
   logic [7:0]  pred_update_index;
   logic        pred_update_taken;
   logic        btb_update_en;
   logic [5:0]  btb_update_index;
   logic [19:0] btb_update_tag;
   logic [31:0] btb_update_target;
   logic        pred_taken;
   logic        pred_btb_hit;
   logic [31:0] pred_target;
   logic [31:0] pred_next_pc;
   logic [1:0]  pred_ctr;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [1:0]  ctr;
      logic        hit;
      logic        taken;
      logic [31:0] target;
      logic [31:0] next;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   failures  = 0;
   logic sample_en = 1'b0;

   always #5 clk = ~clk;

   branch_predictor_btb dut (
      .clk               (clk),
      .reset             (reset),
      .fetch_pc          (fetch_pc),
      .pred_update_en    (pred_update_en),
      .pred_update_index (pred_update_index),
      .pred_update_taken (pred_update_taken),
      .btb_update_en     (btb_update_en),
      .btb_update_index  (btb_update_index),
      .btb_update_tag    (btb_update_tag),
      .btb_update_target (btb_update_target),
      .pred_taken        (pred_taken),
      .pred_btb_hit      (pred_btb_hit),
      .pred_target       (pred_target),
      .pred_next_pc      (pred_next_pc),
      .pred_ctr          (pred_ctr)
   );

   always @(negedge clk) begin
      exp_t e;
      if (sample_en) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow: lookup at pc=%h with no expected entry", fetch_pc);
         end else begin
            e = sb.pop_front();
            if (fetch_pc !== e.pc || pred_ctr !== e.ctr || pred_btb_hit !== e.hit ||
                pred_taken !== e.taken || pred_target !== e.target || pred_next_pc !== e.next) begin
               failures++;
               $display("FAIL %s: pc=%h got ctr=%b hit=%b taken=%b target=%h next=%h, expected ctr=%b hit=%b taken=%b target=%h next=%h",
                        e.name, fetch_pc, pred_ctr, pred_btb_hit, pred_taken, pred_target, pred_next_pc,
                        e.ctr, e.hit, e.taken, e.target, e.next);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      sample_en      = 1'b0;
      pred_update_en = 1'b0;
      btb_update_en  = 1'b0;
   endtask

   task automatic pupd(input logic [7:0] idx, input logic taken);
      pred_update_en    = 1'b1;
      pred_update_index = idx;
      pred_update_taken = taken;
   endtask

   task automatic bupd(input logic [5:0] idx, input logic [19:0] tag, input logic [31:0] tgt);
      btb_update_en     = 1'b1;
      btb_update_index  = idx;
      btb_update_tag    = tag;
      btb_update_target = tgt;
   endtask

   task automatic look(input string nm, input logic [31:0] pc, input logic [1:0] ctr,
                       input logic hit, input logic taken, input logic [31:0] tgt,
                       input logic [31:0] nxt);
      exp_t e;
      fetch_pc = pc;
      e.name = nm; e.pc = pc; e.ctr = ctr; e.hit = hit;
      e.taken = taken; e.target = tgt; e.next = nxt;
      sb.push_back(e);
      sample_en = 1'b1;
      tick();
   endtask

   initial begin
      reset             = 1'b1;
      fetch_pc          = 32'h0;
      pred_update_en    = 1'b0;
      pred_update_index = 8'h0;
      pred_update_taken = 1'b0;
      btb_update_en     = 1'b0;
      btb_update_index  = 6'h0;
      btb_update_tag    = 20'h0;
      btb_update_target = 32'h0;
      tick();
      tick();
      reset = 1'b0;

      look("reset_lookup", 32'h0040_0010, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0040_0014);
      look("pc_wrap",      32'hFFFF_FFFC, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0000_0000);

      // PHT saturation at index 4; each lookup shows the pre-update counter
      pupd(8'h04, 1'b1); look("pht_t1",   32'h0000_0010, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0000_0014);
      pupd(8'h04, 1'b1); look("pht_t2",   32'h0000_0010, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0000_0014);
      pupd(8'h04, 1'b1); look("pht_t3",   32'h0000_0010, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0000_0014);
      pupd(8'h04, 1'b0); look("pht_sat3", 32'h0000_0010, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0000_0014);
      pupd(8'h04, 1'b0); look("pht_n1",   32'h0000_0010, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0000_0014);
      pupd(8'h04, 1'b0); look("pht_n2",   32'h0000_0010, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0000_0014);
      pupd(8'h04, 1'b0); look("pht_n3",   32'h0000_0010, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0000_0014);
      look("pht_sat0", 32'h0000_0010, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0000_0014);

      // Collision: write and lookup same BTB index in one cycle
      bupd(6'h00, 20'h00400, 32'h0040_0100);
      look("collide_old", 32'h0040_0010, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0040_0014);
      pupd(8'h04, 1'b1);
      look("collide_new", 32'h0040_0010, 2'b00, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0014);
      pupd(8'h04, 1'b1);
      look("hit_ctr01",   32'h0040_0010, 2'b01, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0014);
      pupd(8'h04, 1'b0);
      look("hit_taken",   32'h0040_0010, 2'b10, 1'b1, 1'b1, 32'h0040_0100, 32'h0040_0100);
      look("hit_nottkn",  32'h0040_0010, 2'b01, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0014);

      // Tag conflict overwrites index 0
      bupd(6'h00, 20'h00401, 32'h0040_1200);
      look("conflict_old", 32'h0040_0010, 2'b01, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0014);
      look("conflict_miss", 32'h0040_0010, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0040_0014);
      pupd(8'h04, 1'b1);
      look("conflict_hit", 32'h0040_1010, 2'b01, 1'b1, 1'b0, 32'h0040_1200, 32'h0040_1014);
      look("conflict_tkn", 32'h0040_1010, 2'b10, 1'b1, 1'b1, 32'h0040_1200, 32'h0040_1200);

      // Second BTB entry at index 5, PHT index 0x50 untouched
      bupd(6'h05, 20'h00abc, 32'h1234_5678);
      look("idx5_before", 32'h00ab_c140, 2'b01, 1'b0, 1'b0, 32'h0, 32'h00ab_c144);
      look("idx5_hit",    32'h00ab_c140, 2'b01, 1'b1, 1'b0, 32'h1234_5678, 32'h00ab_c144);

      // Reset wins over same-cycle updates
      reset = 1'b1;
      pupd(8'h04, 1'b1);
      bupd(6'h00, 20'h00401, 32'hDEAD_BEEF);
      look("rst_cycle", 32'h0040_1010, 2'b10, 1'b1, 1'b1, 32'h0040_1200, 32'h0040_1200);
      reset = 1'b0;
      look("rst_after_a", 32'h0040_1010, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0040_1014);
      look("rst_after_b", 32'h00ab_c140, 2'b01, 1'b0, 1'b0, 32'h0, 32'h00ab_c144);
      look("rst_after_c", 32'h0040_0010, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0040_0014);

      tick();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
